mux_arbiter_2to1: RTL and testbench

MUX_ARBITER_2TO1 -- requirements
Module: mux_arbiter_2to1

---
 rtl/mux_arbiter_2to1.sv | 145 ++++++++++++++
 tb/tb_mux_arbiter_2to1.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter_2to1.sv
// Two-input packet arbiter with round-robin grant, packet lock, forced release
// after MAX_BEATS beats and a single registered output stage.
module mux_arbiter_2to1 #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_0,
    input  logic             din_0_valid,
    input  logic             din_0_last,
    output logic             din_0_ready,
    input  logic [WIDTH-1:0] din_1,
    input  logic             din_1_valid,
    input  logic             din_1_last,
    output logic             din_1_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             dout_last,
    input  logic             dout_ready,
    output logic             sel,
    output logic             busy,
    output logic             overrun
);

    localparam logic [7:0] MaxBeats = 8'(MAX_BEATS);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             dout_last_q, dout_last_d;
    logic             overrun_q, overrun_d;

    logic             out_free;
    logic             acc;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;
    logic [7:0]       cnt_inc;
    logic             forced;

    // Upstream handshake: only the granted side sees ready, and only when the
    // output register is empty or draining this cycle.
    always_comb begin
        out_free    = !dout_valid_q || dout_ready;
        din_0_ready = (state_q == StGrant0) && out_free;
        din_1_ready = (state_q == StGrant1) && out_free;
        acc         = (din_0_valid && din_0_ready) || (din_1_valid && din_1_ready);
        acc_data    = (state_q == StGrant1) ? din_1 : din_0;
        acc_last    = (state_q == StGrant1) ? din_1_last : din_0_last;
        cnt_inc     = cnt_q + 8'd1;
        // Beat limit reached without a last: close the packet on this beat.
        forced      = acc && !acc_last && (cnt_inc == MaxBeats);
    end

    // Grant FSM: round-robin arbitration in idle, packet lock while granted.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (din_0_valid && din_1_valid) begin
                    // rr names the last served side, so the other one wins.
                    state_d = rr_q ? StGrant0 : StGrant1;
                    sel_d   = !rr_q;
                    rr_d    = !rr_q;
                end else if (din_0_valid) begin
                    state_d = StGrant0;
                    sel_d   = 1'b0;
                    rr_d    = 1'b0;
                end else if (din_1_valid) begin
                    state_d = StGrant1;
                    sel_d   = 1'b1;
                    rr_d    = 1'b1;
                end
            end
            StGrant0, StGrant1: begin
                if (acc) begin
                    cnt_d = cnt_inc;
                    if (acc_last || forced) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output register: load on accept, otherwise drain when downstream takes it.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        overrun_d    = forced;
        if (acc) begin
            dout_d       = acc_data;
            dout_last_d  = acc_last || forced;
            dout_valid_d = 1'b1;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            rr_q         <= 1'b1;
            sel_q        <= 1'b0;
            cnt_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign sel        = sel_q;
    assign busy       = (state_q != StIdle);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Self-checking bench for mux_arbiter_2to1: vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_mux_arbiter_2to1;

    localparam int unsigned W  = 8;
    localparam int unsigned MB = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct {
        logic        v0;
        logic [7:0]  d0;
        logic        l0;
        logic        dr;
        logic [13:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] din_0 = '0;
    logic         din_0_valid = 1'b0;
    logic         din_0_last = 1'b0;
    logic         din_0_ready;
    logic [W-1:0] din_1 = '0;
    logic         din_1_valid = 1'b0;
    logic         din_1_last = 1'b0;
    logic         din_1_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_last;
    logic         dout_ready = 1'b1;
    logic         sel;
    logic         busy;
    logic         overrun;

    mux_arbiter_2to1 #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_0       (din_0),
        .din_0_valid (din_0_valid),
        .din_0_last  (din_0_last),
        .din_0_ready (din_0_ready),
        .din_1       (din_1),
        .din_1_valid (din_1_valid),
        .din_1_last  (din_1_last),
        .din_1_ready (din_1_ready),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_last   (dout_last),
        .dout_ready  (dout_ready),
        .sel         (sel),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Commands applied at the next falling edge.
    logic  rst_cmd = 1'b0;
    logic  dr_cmd  = 1'b1;
    logic  en0 = 1'b1;
    logic  en1 = 1'b1;
    beat_t q0[$];
    beat_t q1[$];
    beat_t out_log[$];
    beat_t exp_q[$];
    int    ov_cnt = 0;

    // Reference model: who owns the output, how many beats so far, and the
    // output register as a 0/1-entry queue.
    bit    m_known = 1'b0;
    int    m_owner = -1;
    int    m_rr    = 1;
    int    m_beats = 0;
    bit    m_sel   = 1'b0;
    bit    m_over  = 1'b0;
    beat_t m_slot[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [13:0] model_vec();
        bit free, dv;
        beat_t b;
        free = (m_slot.size() == 0) || dout_ready;
        dv   = m_slot.size() > 0;
        b    = dv ? m_slot[0] : '0;
        return {m_owner == 0 && free, m_owner == 1 && free, m_owner >= 0, m_sel, dv, m_over,
                b.d, b.l};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {din_0_ready, din_1_ready, busy, sel, dout_valid, overrun,
                dout_valid ? dout : 8'h00, dout_valid & dout_last};
    endfunction

    function automatic void model_step();
        bit    free, acc, forced;
        beat_t b;
        int    win;
        if (!rst_n) begin
            m_known = 1'b1; m_owner = -1; m_rr = 1; m_beats = 0;
            m_sel = 1'b0; m_over = 1'b0; m_slot.delete();
            return;
        end
        if (!m_known) return;
        free   = (m_slot.size() == 0) || dout_ready;
        acc    = free && ((m_owner == 0 && din_0_valid) || (m_owner == 1 && din_1_valid));
        forced = 1'b0;
        if (dout_ready && m_slot.size() > 0) void'(m_slot.pop_front());
        if (m_owner < 0) begin
            win = -1;
            if (din_0_valid && din_1_valid) win = 1 - m_rr;
            else if (din_0_valid) win = 0;
            else if (din_1_valid) win = 1;
            if (win >= 0) begin
                m_owner = win; m_rr = win; m_sel = (win == 1); m_beats = 0;
            end
        end else if (acc) begin
            b = (m_owner == 0) ? {din_0, din_0_last} : {din_1, din_1_last};
            m_beats++;
            forced = !b.l && (m_beats == int'(MB));
            m_slot.push_back({b.d, b.l | forced});
            if (b.l || forced) m_owner = -1;
        end
        m_over = forced;
    endfunction

    // Sample just after inputs settle, compare against the model, then advance it.
    task automatic settle_check_step(output bit hs0, output bit hs1);
        #1;
        if (m_known) check("model", 32'(dut_vec()), 32'(model_vec()));
        if (rst_n && dout_valid && dout_ready) out_log.push_back({dout, dout_last});
        if (rst_n && overrun) ov_cnt++;
        hs0 = rst_n && din_0_valid && din_0_ready;
        hs1 = rst_n && din_1_valid && din_1_ready;
        model_step();
    endtask

    task automatic src_cycle(output bit hs0, output bit hs1);
        @(negedge clk);
        rst_n       = rst_cmd;
        dout_ready  = dr_cmd;
        din_0_valid = en0 && (q0.size() > 0);
        din_0       = din_0_valid ? q0[0].d : 8'h00;
        din_0_last  = din_0_valid ? q0[0].l : 1'b0;
        din_1_valid = en1 && (q1.size() > 0);
        din_1       = din_1_valid ? q1[0].d : 8'h00;
        din_1_last  = din_1_valid ? q1[0].l : 1'b0;
        settle_check_step(hs0, hs1);
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
    endtask

    task automatic do_reset(input int n);
        bit h0, h1;
        rst_cmd = 1'b0;
        repeat (n) src_cycle(h0, h1);
        rst_cmd = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        bit h0, h1;
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            src_cycle(h0, h1);
            n++;
            done = q0.size() == 0 && q1.size() == 0 && m_owner < 0 && m_slot.size() == 0;
        end
        check({name, "_timeout"}, 32'(done), 32'd1);
        src_cycle(h0, h1);
    endtask

    task automatic wait_hs0(input string name, input int target);
        bit h0, h1;
        int cnt, n;
        cnt = 0;
        n = 0;
        while (cnt < target && n < 50) begin
            src_cycle(h0, h1);
            if (h0) cnt++;
            n++;
        end
        check({name, "_hs_timeout"}, 32'(cnt), 32'(target));
    endtask

    task automatic check_stream(input string name);
        check({name, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
            check($sformatf("%s[%0d]", name, i), 32'(out_log[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_state(input string name);
        check(name, {24'h0, din_0_ready, din_1_ready, busy, sel, dout_valid, dout_last, overrun,
                     |dout}, 32'h0);
    endtask

    function automatic void push_pkt(input int side, input logic [7:0] base, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = {base + 8'(i), i == len - 1};
            if (side == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        bit   h0, h1;
        beat_t b;

        // Single 3-beat packet on requester 0 with downstream always ready.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, {5'b00000, 8'h00, 1'b0}};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 1'b1, {5'b10100, 8'h00, 1'b0}};
        tbl[2] = '{1'b1, 8'h22, 1'b0, 1'b1, {5'b10101, 8'h11, 1'b0}};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 1'b1, {5'b10101, 8'h22, 1'b0}};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, {5'b00001, 8'h33, 1'b1}};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b1, {5'b00000, 8'h00, 1'b0}};

        do_reset(2);
        check_reset_state("reset_state");

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n       = 1'b1;
            dout_ready  = tbl[i].dr;
            din_0_valid = tbl[i].v0;
            din_0       = tbl[i].d0;
            din_0_last  = tbl[i].l0;
            din_1_valid = 1'b0;
            din_1       = 8'h00;
            din_1_last  = 1'b0;
            settle_check_step(h0, h1);
            check($sformatf("vec[%0d]", i),
                  32'({din_0_ready, din_1_ready, busy, sel, dout_valid,
                       dout_valid ? dout : 8'h00, dout_valid & dout_last}),
                  32'(tbl[i].exp));
        end

        // Contention from reset: 0, then 1, then 0 again.
        push_pkt(0, 8'hA0, 2); push_pkt(1, 8'hB0, 2);
        push_pkt(0, 8'hC0, 2); push_pkt(1, 8'hD0, 2);
        do_reset(1);
        out_log.delete();
        drain("contention", 100);
        exp_q.delete();
        exp_q = '{{8'hA0, 1'b0}, {8'hA1, 1'b1}, {8'hB0, 1'b0}, {8'hB1, 1'b1},
                  {8'hC0, 1'b0}, {8'hC1, 1'b1}, {8'hD0, 1'b0}, {8'hD1, 1'b1}};
        check_stream("contention");

        // Backpressure for 4 cycles mid-packet.
        do_reset(1);
        out_log.delete();
        push_pkt(0, 8'h41, 4);
        wait_hs0("bp", 2);
        dr_cmd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            src_cycle(h0, h1);
            check($sformatf("bp_stall[%0d]", i), {22'h0, din_0_ready, dout_valid, dout},
                  {22'h0, 1'b0, 1'b1, 8'h42});
        end
        dr_cmd = 1'b1;
        drain("bp", 50);
        exp_q = '{{8'h41, 1'b0}, {8'h42, 1'b0}, {8'h43, 1'b0}, {8'h44, 1'b1}};
        check_stream("bp");

        // Overrun: 6-beat packet with a 4-beat limit.
        do_reset(1);
        out_log.delete();
        push_pkt(1, 8'h61, 6);
        ov_cnt = 0;
        drain("ovr", 50);
        exp_q = '{{8'h61, 1'b0}, {8'h62, 1'b0}, {8'h63, 1'b0}, {8'h64, 1'b1},
                  {8'h65, 1'b0}, {8'h66, 1'b1}};
        check_stream("ovr");
        check("ovr_pulses", 32'(ov_cnt), 32'd1);

        // Valid gap on the owner while the other side waits.
        do_reset(1);
        out_log.delete();
        push_pkt(0, 8'h51, 4); push_pkt(1, 8'h71, 1);
        wait_hs0("gap", 2);
        en0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_cycle(h0, h1);
            check($sformatf("gap_hold[%0d]", i), {29'h0, din_1_ready, sel, busy}, 32'h1);
        end
        en0 = 1'b1;
        drain("gap", 50);
        exp_q = '{{8'h51, 1'b0}, {8'h52, 1'b0}, {8'h53, 1'b0}, {8'h54, 1'b1}, {8'h71, 1'b1}};
        check_stream("gap");

        // Reset after the 2nd of 4 beats; requester 0 must win afterwards.
        do_reset(1);
        push_pkt(0, 8'h81, 4);
        wait_hs0("midrst", 2);
        q0.delete();
        do_reset(1);
        push_pkt(0, 8'h91, 1); push_pkt(1, 8'hE1, 1);
        src_cycle(h0, h1);
        check_reset_state("midrst_state");
        out_log.delete();
        drain("midrst", 50);
        exp_q = '{{8'h91, 1'b1}, {8'hE1, 1'b1}};
        check_stream("midrst");

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() == 0 && $urandom_range(0, 3) == 0)
                push_pkt(0, 8'($urandom), int'($urandom_range(1, 7)));
            if (q1.size() == 0 && $urandom_range(0, 3) == 0)
                push_pkt(1, 8'($urandom), int'($urandom_range(1, 7)));
            en0     = $urandom_range(0, 4) != 0;
            en1     = $urandom_range(0, 4) != 0;
            dr_cmd  = $urandom_range(0, 3) != 0;
            rst_cmd = $urandom_range(0, 199) != 0;
            src_cycle(h0, h1);
        end
        b = '0;
        if (b.l) $display("unreachable");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
